// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one external ALU: accept one request, register operands, capture result.
// Optional macro ALU_ARB_RR_EN selects round-robin tie-breaking; default is fixed priority (port 0).
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [3:0]       req_ctrl0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_ctrl1,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
    logic [3:0]       alu_ctrl_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_zero_reg;
    logic [1:0]       rsp_valid_reg;
    logic             grant_id_reg;

    // Per-port operand views so the accept path can be indexed by the winner.
    logic [WIDTH-1:0] port_a [2];
    logic [WIDTH-1:0] port_b [2];
    logic [3:0]       port_ctrl [2];

    assign port_a[0]    = req_a0;
    assign port_b[0]    = req_b0;
    assign port_ctrl[0] = req_ctrl0;
    assign port_a[1]    = req_a1;
    assign port_b[1]    = req_b1;
    assign port_ctrl[1] = req_ctrl1;

    logic grant_sel;
    logic can_accept;
    logic accept;

`ifdef ALU_ARB_RR_EN
    logic last_grant_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= grant_sel;
        end
    end

    always_comb begin
        grant_sel = 1'b0;
        if (req_valid == 2'b11) begin
            grant_sel = ~last_grant_reg;
        end else begin
            grant_sel = ~req_valid[0];
        end
    end
`else
    // Port 0 wins whenever it is valid; port 1 only when it is alone.
    always_comb begin
        grant_sel = 1'b0;
        if (!req_valid[0]) begin
            grant_sel = 1'b1;
        end
    end
`endif

    assign can_accept = rst_n && (state_reg == IDLE) && (req_valid != 2'b00);
    assign accept     = can_accept;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = can_accept && (grant_sel == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= '0;
            grant_id_reg   <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_valid_reg  <= 2'b00;
        end else begin
            rsp_valid_reg <= 2'b00;
            if (state_reg == IDLE) begin
                if (accept) begin
                    alu_a_reg    <= port_a[grant_sel];
                    alu_b_reg    <= port_b[grant_sel];
                    alu_ctrl_reg <= port_ctrl[grant_sel];
                    grant_id_reg <= grant_sel;
                end
            end else begin
                rsp_result_reg               <= alu_result;
                rsp_zero_reg                 <= alu_zero;
                rsp_valid_reg[grant_id_reg]  <= 1'b1;
            end
        end
    end

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_ctrl   = alu_ctrl_reg;
    assign grant_id   = grant_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign busy       = (state_reg == EXEC);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU stub on the alu_* ports.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]       req_ctrl0, req_ctrl1;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             busy;
    logic             grant_id;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_ctrl0(req_ctrl0),
        .req_a1(req_a1), .req_b1(req_b1), .req_ctrl1(req_ctrl1),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    logic mon_en = 1'b0;

    // Reference model of the arbiter's externally visible state.
    logic        m_exec;
    logic        m_last;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_c;
    logic        m_gid;
    logic [31:0] m_rsp;
    logic        m_zero;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rsp_valid != 2'b00) begin
                check("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_valid), e.id ? 64'd2 : 64'd1);
                    check("rsp_result", 64'(rsp_result), 64'(e.res));
                    check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
                    check("rsp_latency", 64'(cyc), 64'(e.due));
                    $display("rsp cyc=%0d port=%0d result=0x%08h zero=%0b", cyc, e.id, rsp_result, rsp_zero);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                check("rsp_missing_at", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic rstn, input logic [1:0] v,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1);
        logic [1:0]  exp_ready;
        logic        win;
        logic [31:0] wa, wb, r;
        logic [3:0]  wc;
        exp_t        e;
        @(negedge clk);
        rst_n = rstn; req_valid = v;
        req_a0 = a0; req_b0 = b0; req_ctrl0 = c0;
        req_a1 = a1; req_b1 = b1; req_ctrl1 = c1;
        #1;
        win = 1'b0;
        if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            win = ~m_last;
`else
            win = 1'b0;
`endif
        end else if (v == 2'b10) begin
            win = 1'b1;
        end
        exp_ready = (rstn && !m_exec && v != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'(m_exec));
        check("alu_a", 64'(alu_a), 64'(m_a));
        check("alu_b", 64'(alu_b), 64'(m_b));
        check("alu_ctrl", 64'(alu_ctrl), 64'(m_c));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("rsp_result_hold", 64'(rsp_result), 64'(m_rsp));
        check("rsp_zero_hold", 64'(rsp_zero), 64'(m_zero));
        if (!rstn) begin
            if (m_exec && sb.size() > 0) void'(sb.pop_back());
            m_exec = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_c = '0;
            m_gid = 1'b0; m_rsp = '0; m_zero = 1'b0;
        end else if (m_exec) begin
            m_exec = 1'b0;
            m_rsp  = alu_fn(m_a, m_b, m_c);
            m_zero = (m_rsp == 32'd0);
        end else if (exp_ready != 2'b00) begin
            wa = win ? a1 : a0; wb = win ? b1 : b0; wc = win ? c1 : c0;
            r = alu_fn(wa, wb, wc);
            e.id = win; e.res = r; e.zero = (r == 32'd0); e.due = cyc + 2;
            sb.push_back(e);
            $display("acc cyc=%0d port=%0d a=0x%08h b=0x%08h ctrl=%0h", cyc, win, wa, wb, wc);
            m_exec = 1'b1; m_last = win; m_a = wa; m_b = wb; m_c = wc; m_gid = win;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    logic [3:0] ctrl_tab [6];

    initial begin
        ctrl_tab[0] = C_AND; ctrl_tab[1] = C_OR; ctrl_tab[2] = C_ADD;
        ctrl_tab[3] = C_SUB; ctrl_tab[4] = 4'b0111; ctrl_tab[5] = 4'b1100;
        rst_n = 1'b0; req_valid = 2'b00;
        req_a0 = '0; req_b0 = '0; req_ctrl0 = '0;
        req_a1 = '0; req_b1 = '0; req_ctrl1 = '0;
        m_exec = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_c = '0;
        m_gid = 1'b0; m_rsp = '0; m_zero = 1'b0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Reset state, and req_ready forced low while rst_n is low.
        step(1'b0, 2'b11, 1, 2, C_ADD, 3, 4, C_ADD);
        idle(1);

        // Single request on port 0: 10 + 5.
        step(1'b1, 2'b01, 10, 5, C_ADD, 0, 0, 0);
        idle(3);

        // Zero flag via port 1: 7 - 7.
        step(1'b1, 2'b10, 0, 0, 0, 7, 7, C_SUB);
        idle(3);

        // Continuous tie: both ports valid every cycle.
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b11, 32'hF0F0, 32'h0FF0, C_AND, 32'hF0F0, 32'h0FF0, C_OR);
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'b10, 0, 0, 0, 32'hF0F0, 32'h0FF0, C_OR);
        idle(3);

        // Port 1 request withdrawn while port 0 is executing.
        step(1'b1, 2'b01, 100, 1, C_SUB, 0, 0, 0);
        step(1'b1, 2'b10, 0, 0, 0, 55, 66, C_ADD);
        idle(3);

        // Reset during EXEC, then a fresh request.
        step(1'b1, 2'b01, 32'h1234, 32'h1111, C_ADD, 0, 0, 0);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1'b1, 2'b10, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, C_ADD);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 60; i++)
            step(1'b1, 2'($urandom_range(0, 3)),
                 $urandom, $urandom, ctrl_tab[$urandom_range(0, 5)],
                 $urandom, $urandom, ctrl_tab[$urandom_range(0, 5)]);
        idle(4);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
